// File: rtl/ingress_pkg.sv
// ingress_pkg: shared widths and helpers for the ingress VOQ buffer
package ingress_pkg;
    localparam int PORT_CNT   = 4;
    localparam int PACKET_CNT = 1024;
    localparam int META_WIDTH = 32;
    localparam int PORT_IDX_W = $clog2(PORT_CNT);
    localparam int DEPTH_W    = $clog2(PACKET_CNT / PORT_CNT);
    localparam int CNT_W      = DEPTH_W + 1;

    function automatic logic [PORT_IDX_W-1:0] dest_of(input logic [META_WIDTH-1:0] meta);
        return meta[META_WIDTH-1 -: PORT_IDX_W];
    endfunction
endpackage

// File: rtl/simple_dual_port_mem.sv
// simple_dual_port_mem: one write port, one registered read port
module simple_dual_port_mem #(
    parameter int MEM_SIZE   = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

    // Storage array; read data only changes on an enabled read so it holds otherwise
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
    end
endmodule

// File: rtl/ingress_voq.sv
// ingress_voq: sorts ingress metadata into per-destination VOQs and pops on scheduler grant
module ingress_voq
    import ingress_pkg::*;
#(
    parameter int PORT_CNT   = ingress_pkg::PORT_CNT,
    parameter int PACKET_CNT = ingress_pkg::PACKET_CNT,
    parameter int META_WIDTH = ingress_pkg::META_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [META_WIDTH-1:0]       ingress_in,
    input  logic                        ingress_in_en,
    output logic [PORT_CNT-1:0]         voq_full,
    input  logic                        sched_grant_en,
    input  logic [PORT_IDX_W-1:0]       sched_grant_port,
    output logic [PORT_CNT*CNT_W-1:0]   voq_len,
    output logic [META_WIDTH-1:0]       ingress_out,
    output logic                        ingress_out_en,
    output logic [15:0]                 drop_cnt
);
    localparam int DEPTH = PACKET_CNT / PORT_CNT;

    logic [PORT_IDX_W-1:0]                dest;
    logic [PORT_CNT-1:0][DEPTH_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PORT_CNT-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [PORT_CNT-1:0]                  push, pop, full_q;
    logic                                 out_en_q, have_q, drop;
    logic [15:0]                          drop_q;
    logic [META_WIDTH-1:0]                rd_data;

    assign dest = dest_of(ingress_in);
    // Full is judged on the pre-cycle count, so a same-cycle pop never rescues a push
    assign drop = ingress_in_en && cnt_q[dest] == CNT_W'(DEPTH);

    for (genvar p = 0; p < PORT_CNT; p++) begin : g_voq
        assign push[p]   = ingress_in_en && dest == PORT_IDX_W'(p) && cnt_q[p] != CNT_W'(DEPTH);
        assign pop[p]    = sched_grant_en && sched_grant_port == PORT_IDX_W'(p) && cnt_q[p] != '0;
        assign tail_d[p] = tail_q[p] + DEPTH_W'(push[p]);
        assign head_d[p] = head_q[p] + DEPTH_W'(pop[p]);
        assign cnt_d[p]  = cnt_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
    end

    simple_dual_port_mem #(
        .MEM_SIZE   (PACKET_CNT),
        .DATA_WIDTH (META_WIDTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (|push),
        .wr_addr_i ({dest, tail_q[dest]}),
        .wr_data_i (ingress_in),
        .rd_en_i   (|pop),
        .rd_addr_i ({sched_grant_port, head_q[sched_grant_port]}),
        .rd_data_o (rd_data)
    );

    // Pointer, count, full flag and drop counter state for all VOQs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            full_q   <= '0;
            out_en_q <= 1'b0;
            have_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < PORT_CNT; i++) full_q[i] <= cnt_d[i] == CNT_W'(DEPTH);
            out_en_q <= |pop;
            have_q   <= have_q | (|pop);
            drop_q   <= (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        end
    end

    assign voq_full       = full_q;
    assign voq_len        = cnt_q;
    assign ingress_out_en = out_en_q;
    // Memory read data is not reset, so mask it until the first pop after reset
    assign ingress_out    = have_q ? rd_data : '0;
    assign drop_cnt       = drop_q;
endmodule

// File: tb/tb_ingress_voq.sv
// tb_ingress_voq: scoreboard bench with a queue-based reference model of the VOQ buffer
module tb_ingress_voq;
    localparam int NP = 4;
    localparam int DEPTH = 256;
    localparam int CW = 9;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [31:0] ingress_in = '0;
    logic ingress_in_en = 1'b0;
    logic [NP-1:0] voq_full;
    logic sched_grant_en = 1'b0;
    logic [1:0] sched_grant_port = '0;
    logic [NP*CW-1:0] voq_len;
    logic [31:0] ingress_out;
    logic ingress_out_en;
    logic [15:0] drop_cnt;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] mq [NP][$];
    logic [31:0] exp_q [$];
    logic [31:0] last_out = '0;
    int drops = 0;

    ingress_voq dut (
        .clk(clk), .reset(reset), .ingress_in(ingress_in), .ingress_in_en(ingress_in_en),
        .voq_full(voq_full), .sched_grant_en(sched_grant_en), .sched_grant_port(sched_grant_port),
        .voq_len(voq_len), .ingress_out(ingress_out), .ingress_out_en(ingress_out_en),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [NP*CW-1:0] exp_len();
        logic [NP*CW-1:0] v = '0;
        for (int p = 0; p < NP; p++) v[p*CW +: CW] = CW'(mq[p].size());
        return v;
    endfunction

    function automatic logic [NP-1:0] exp_full();
        logic [NP-1:0] v = '0;
        for (int p = 0; p < NP; p++) v[p] = mq[p].size() == DEPTH;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops expected words on each output strobe and checks status against the model
    always @(negedge clk) begin
        if (reset) begin
            if (ingress_out_en) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL spurious_out: got en=1 data %0h expected no output at %0t", ingress_out, $time);
                end else begin
                    last_out = exp_q.pop_front();
                    if (ingress_out !== last_out) begin
                        mismatched++;
                        $display("FAIL out_data: got %0h expected %0h at %0t", ingress_out, last_out, $time);
                    end
                end
            end
            check("missing_out", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            check("out_hold", 64'(ingress_out), 64'(last_out));
            check("voq_len", 64'(voq_len), 64'(exp_len()));
            check("voq_full", 64'(voq_full), 64'(exp_full()));
            check("drop_cnt", 64'(drop_cnt), 64'(drops));
        end
    end

    task automatic drive(input bit en, input logic [31:0] w, input bit ge, input logic [1:0] gp);
        int d;
        bit pok, gok;
        @(negedge clk);
        #1;
        ingress_in_en = en;
        ingress_in = w;
        sched_grant_en = ge;
        sched_grant_port = gp;
        d = int'(w[31:30]);
        pok = en && mq[d].size() < DEPTH;
        gok = ge && mq[gp].size() > 0;
        if (gok) exp_q.push_back(mq[gp].pop_front());
        if (pok) mq[d].push_back(w);
        else if (en && drops < 65535) drops++;
    endtask

    function automatic logic [31:0] word(input int d);
        logic [31:0] r = $urandom;
        r[31:30] = 2'(d);
        return r;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        idle(1);
        // three words to VOQ2, then three grants
        for (int i = 1; i <= 3; i++) drive(1, 32'h8000_0000 + 32'(i), 0, '0);
        for (int i = 0; i < 3; i++) drive(0, '0, 1, 2'd2);
        idle(2);
        // fill VOQ0, one overflow, then push+grant on full VOQ0, then drain
        for (int i = 0; i < DEPTH; i++) drive(1, word(0), 0, '0);
        drive(1, word(0), 0, '0);
        drive(1, word(0), 1, 2'd0);
        for (int i = 0; i < DEPTH - 1; i++) drive(0, '0, 1, 2'd0);
        idle(1);
        // grant to empty VOQ1
        drive(0, '0, 1, 2'd1);
        idle(1);
        // same-VOQ push+pop with five queued, and cross-VOQ push+pop
        for (int i = 0; i < 5; i++) drive(1, word(3), 0, '0);
        drive(1, word(0), 0, '0);
        drive(1, word(3), 1, 2'd3);
        drive(1, word(1), 1, 2'd0);
        // empty VOQ2 pushed and granted in the same cycle
        drive(1, word(2), 1, 2'd2);
        idle(2);
        // randomized fill-heavy then drain-heavy traffic
        for (int i = 0; i < 2500; i++)
            drive($urandom_range(0, 9) < 9, word($urandom_range(0, 3)), $urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)));
        for (int i = 0; i < 2500; i++)
            drive($urandom_range(0, 9) < 2, word($urandom_range(0, 3)), $urandom_range(0, 9) < 9, 2'($urandom_range(0, 3)));
        // reset mid-stream with ten words queued and a grant in flight
        for (int i = 0; i < 10; i++) drive(1, word($urandom_range(0, 3)), 0, '0);
        drive(0, '0, 1, 2'd0);
        drive(0, '0, 1, 2'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_out", 64'(ingress_out), 64'd0);
        check("rst_out_en", 64'(ingress_out_en), 64'd0);
        check("rst_voq_len", 64'(voq_len), 64'd0);
        check("rst_voq_full", 64'(voq_full), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        for (int p = 0; p < NP; p++) mq[p].delete();
        exp_q.delete();
        last_out = '0;
        drops = 0;
        ingress_in_en = 1'b0;
        sched_grant_en = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        // traffic after reset
        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 1) == 1, word($urandom_range(0, 3)), $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
        for (int i = 0; i < DEPTH * NP; i++) drive(0, '0, 1, 2'(i % NP));
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
